// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a sync_fifo (1-cycle read latency) into a
// valid/ready stream, cut into packets of PKT_LEN words.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                run enable (high = stream words out of the FIFO)
//   fifo_empty        empty flag from the upstream sync_fifo
//   fifo_rd_data      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en        read strobe to the FIFO
//   out_valid/ready   downstream handshake
//   out_data          streamed word (oldest buffered entry)
//   out_last          final word of a packet
//   pkt_count         packets completed since reset (wraps)
//   busy              high whenever the controller is not IDLE

module fifo_rd_stream #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      pkt_count,
    output logic             busy
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   iss_cnt;
    logic [CW-1:0]   out_cnt;
    logic [1:0]      occ;
    logic            inflight;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    logic            xfer;
    logic            issue_ok;
    logic [1:0]      level;

    assign xfer = out_valid & out_ready;

    // Words held or on their way once this cycle's transfer is counted.
    // occ=2 never coincides with a read in flight, so 2 bits suffice.
    assign level = occ + {1'b0, inflight} - {1'b0, xfer};

    // STOP keeps issuing only to finish the packet already started.
    assign issue_ok = (state == RUN) |
                      ((state == STOP) & (iss_cnt != '0));

    assign fifo_rd_en = issue_ok & ~fifo_empty & (level < 2'd2);

    assign out_valid = (occ != 2'd0);
    assign out_data  = slot0;
    assign out_last  = out_valid & (out_cnt == LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            iss_cnt   <= '0;
            out_cnt   <= '0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            slot0     <= '0;
            slot1     <= '0;
            pkt_count <= 16'd0;
        end else begin
            inflight <= fifo_rd_en;

            if (fifo_rd_en) begin
                iss_cnt <= (iss_cnt == LAST) ? '0 : iss_cnt + 1'b1;
            end

            if (xfer) begin
                out_cnt <= (out_cnt == LAST) ? '0 : out_cnt + 1'b1;
                if (out_last) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end

            // slot0 is always the head; slot1 only fills when the
            // head is still waiting on the downstream.
            case ({inflight, xfer})
                2'b10: begin
                    if (occ == 2'd0) begin
                        slot0 <= fifo_rd_data;
                    end else begin
                        slot1 <= fifo_rd_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        slot0 <= fifo_rd_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (en) begin
                        state <= RUN;
                    end else if ((iss_cnt == '0) && (occ == 2'd0) &&
                                 !inflight) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: self-checking bench for fifo_rd_stream.
// Two instances: PKT_LEN=4 (unit a) and PKT_LEN=1 (unit b).

module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       out_ready;

    logic       fifo_empty_a;
    logic [7:0] fifo_rd_data_a;
    logic       fifo_rd_en_a;
    logic       out_valid_a;
    logic [7:0] out_data_a;
    logic       out_last_a;
    logic [15:0] pkt_count_a;
    logic       busy_a;

    logic       fifo_empty_b;
    logic [7:0] fifo_rd_data_b;
    logic       fifo_rd_en_b;
    logic       out_valid_b;
    logic [7:0] out_data_b;
    logic       out_last_b;
    logic [15:0] pkt_count_b;
    logic       busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(8), .PKT_LEN(4)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty_a),
        .fifo_rd_data (fifo_rd_data_a),
        .fifo_rd_en   (fifo_rd_en_a),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready),
        .out_data     (out_data_a),
        .out_last     (out_last_a),
        .pkt_count    (pkt_count_a),
        .busy         (busy_a)
    );

    fifo_rd_stream #(.WIDTH(8), .PKT_LEN(1)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty_b),
        .fifo_rd_data (fifo_rd_data_b),
        .fifo_rd_en   (fifo_rd_en_b),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready),
        .out_data     (out_data_b),
        .out_last     (out_last_b),
        .pkt_count    (pkt_count_b),
        .busy         (busy_b)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         c;
    } obs_t;

    logic [7:0] fq_a[$];
    logic [7:0] fq_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    obs_t       obs_a[$];
    obs_t       obs_b[$];

    int cyc = 0;
    int held_a = 0;
    int rd_total_a = 0;
    int pop_err_a = 0;
    int pop_err_b = 0;
    int rdemp_err_a = 0;
    int over_err_a = 0;
    int stab_err_a = 0;
    int widx_a = 0;
    int npkt_a = 0;

    int         xa;
    logic       hold_a = 1'b0;
    logic [7:0] hd_a;
    logic       hl_a;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sync_fifo with 1-cycle read latency.
    always @(posedge clk) begin
        if (fifo_rd_en_a) begin
            rd_total_a <= rd_total_a + 1;
            if (fq_a.size() > 0) fifo_rd_data_a <= fq_a.pop_front();
            else pop_err_a <= pop_err_a + 1;
        end
        if (fifo_rd_en_b) begin
            if (fq_b.size() > 0) fifo_rd_data_b <= fq_b.pop_front();
            else pop_err_b <= pop_err_b + 1;
        end
    end

    // Words issued but not yet handed downstream.
    always @(posedge clk or posedge rst) begin
        if (rst) held_a <= 0;
        else held_a <= held_a + (fifo_rd_en_a ? 1 : 0)
                       - ((out_valid_a && out_ready) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_a = 1'b0;
        end else begin
            xa = (out_valid_a && out_ready) ? 1 : 0;
            if (fifo_rd_en_a && fifo_empty_a) rdemp_err_a++;
            if (fifo_rd_en_a && (held_a - xa) >= 2) over_err_a++;
            if (hold_a && (!out_valid_a || out_data_a !== hd_a ||
                           out_last_a !== hl_a)) stab_err_a++;
            hold_a = out_valid_a && !out_ready;
            hd_a = out_data_a;
            hl_a = out_last_a;
            if (xa == 1) obs_a.push_back('{out_data_a, out_last_a, cyc});
            if (out_valid_b && out_ready)
                obs_b.push_back('{out_data_b, out_last_b, cyc});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        fifo_empty_a = (fq_a.size() == 0);
        fifo_empty_b = (fq_b.size() == 0);
    endtask

    task automatic push_a(input logic [7:0] v);
        fq_a.push_back(v);
        exp_a.push_back(v);
        fifo_empty_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] v);
        fq_b.push_back(v);
        exp_b.push_back(v);
        fifo_empty_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        fifo_empty_a = 1'b1;
        fifo_empty_b = 1'b1;
        #3;
        checks++;
        if ({fifo_rd_en_a, out_valid_a, out_data_a, out_last_a, busy_a} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outs_a got %b need 0",
                     {fifo_rd_en_a, out_valid_a, out_data_a, out_last_a, busy_a});
        end
        checks++;
        if (pkt_count_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_pkt_a got %0d need 0", pkt_count_a);
        end
        checks++;
        if ({fifo_rd_en_b, out_valid_b, out_last_b, busy_b, pkt_count_b} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outs_b got %b need 0",
                     {fifo_rd_en_b, out_valid_b, out_last_b, busy_b, pkt_count_b});
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        obs_t o;
        logic [7:0] e;
        logic el;
        int prev_c;
        for (int i = 1; i <= 8; i++) push_a(8'(i));
        out_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 100 && obs_a.size() < 8; i++) step();
        step();
        checks++;
        if (obs_a.size() != 8) begin
            errors++;
            $display("FAIL basic_count got %0d need 8", obs_a.size());
        end
        prev_c = -1;
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL basic_extra got %h need none", o.d);
            end else begin
                e = exp_a.pop_front();
                el = (widx_a % 4 == 3);
                if (o.d !== e || o.l !== el) begin
                    errors++;
                    $display("FAIL basic_word got %h/%b need %h/%b",
                             o.d, o.l, e, el);
                end
                widx_a++;
                if (el) npkt_a++;
            end
            if (prev_c >= 0) begin
                checks++;
                if (o.c != prev_c + 1) begin
                    errors++;
                    $display("FAIL basic_gap got %0d need 1", o.c - prev_c);
                end
            end
            prev_c = o.c;
        end
        checks++;
        if (pkt_count_a !== 16'd2) begin
            errors++;
            $display("FAIL basic_pkt got %0d need 2", pkt_count_a);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [7:0] e;
        logic el;
        int s0, v0, n;
        s0 = stab_err_a;
        v0 = over_err_a;
        n = 0;
        for (int i = 0; i < 12; i++) push_a(8'($urandom));
        for (int k = 0; k < 120 && obs_a.size() < 12; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
        end
        out_ready = 1'b1;
        step();
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            n++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL bp_extra got %h need none", o.d);
            end else begin
                e = exp_a.pop_front();
                el = (widx_a % 4 == 3);
                if (o.d !== e || o.l !== el) begin
                    errors++;
                    $display("FAIL bp_word got %h/%b need %h/%b",
                             o.d, o.l, e, el);
                end
                widx_a++;
                if (el) npkt_a++;
            end
        end
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL bp_count got %0d need 12", n);
        end
        checks++;
        if (stab_err_a != s0) begin
            errors++;
            $display("FAIL bp_stable got %0d need %0d", stab_err_a, s0);
        end
        checks++;
        if (over_err_a != v0) begin
            errors++;
            $display("FAIL bp_overfill got %0d need %0d", over_err_a, v0);
        end
        checks++;
        if (pkt_count_a !== 16'(npkt_a)) begin
            errors++;
            $display("FAIL bp_pkt got %0d need %0d", pkt_count_a, npkt_a);
        end
    endtask

    task automatic test_stop();
        obs_t o;
        logic [7:0] e;
        logic el;
        int r0, n;
        n = 0;
        r0 = rd_total_a;
        push_a(8'h21);
        push_a(8'h22);
        for (int i = 0; i < 50 && rd_total_a < r0 + 2; i++) step();
        en = 1'b0;
        step();
        for (int i = 3; i <= 6; i++) push_a(8'(8'h20 + i));
        for (int i = 0; i < 60 && busy_a; i++) step();
        step();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL stop_busy got %b need 0", busy_a);
        end
        checks++;
        if (rd_total_a - r0 != 4) begin
            errors++;
            $display("FAIL stop_reads got %0d need 4", rd_total_a - r0);
        end
        checks++;
        if (fq_a.size() != 2) begin
            errors++;
            $display("FAIL stop_left got %0d need 2", fq_a.size());
        end
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            n++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL stop_extra got %h need none", o.d);
            end else begin
                e = exp_a.pop_front();
                el = (widx_a % 4 == 3);
                if (o.d !== e || o.l !== el) begin
                    errors++;
                    $display("FAIL stop_word got %h/%b need %h/%b",
                             o.d, o.l, e, el);
                end
                widx_a++;
                if (el) npkt_a++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL stop_count got %0d need 4", n);
        end
    endtask

    task automatic test_empty_stall();
        obs_t o;
        logic [7:0] e;
        logic el;
        int r0, n;
        n = 0;
        en = 1'b1;
        for (int i = 0; i < 50 && obs_a.size() < 2; i++) step();
        repeat (5) step();
        checks++;
        if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_run got busy=%b valid=%b need 1/0",
                     busy_a, out_valid_a);
        end
        push_a(8'h31);
        push_a(8'h32);
        for (int i = 0; i < 50 && obs_a.size() < 4; i++) step();
        r0 = rd_total_a;
        push_a(8'h41);
        for (int i = 0; i < 50 && rd_total_a < r0 + 1; i++) step();
        en = 1'b0;
        repeat (5) step();
        checks++;
        if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_stop got busy=%b valid=%b need 1/0",
                     busy_a, out_valid_a);
        end
        for (int i = 2; i <= 6; i++) push_a(8'(8'h40 + i));
        for (int i = 0; i < 60 && busy_a; i++) step();
        step();
        checks++;
        if (rd_total_a - r0 != 4 || fq_a.size() != 2) begin
            errors++;
            $display("FAIL stall_reads got %0d/%0d need 4/2",
                     rd_total_a - r0, fq_a.size());
        end
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            n++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL stall_extra got %h need none", o.d);
            end else begin
                e = exp_a.pop_front();
                el = (widx_a % 4 == 3);
                if (o.d !== e || o.l !== el) begin
                    errors++;
                    $display("FAIL stall_word got %h/%b need %h/%b",
                             o.d, o.l, e, el);
                end
                widx_a++;
                if (el) npkt_a++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL stall_count got %0d need 8", n);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [7:0] e;
        logic el;
        int n;
        n = 0;
        out_ready = 1'b0;
        push_a(8'h51);
        push_a(8'h52);
        en = 1'b1;
        for (int i = 0; i < 50 && !(held_a == 2 && out_valid_a); i++) step();
        checks++;
        if (held_a != 2 || out_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL rmid_setup got held=%0d valid=%b need 2/1",
                     held_a, out_valid_a);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rd_en_a, out_valid_a, out_data_a, out_last_a, busy_a} !== 12'd0) begin
            errors++;
            $display("FAIL rmid_outs got %b need 0",
                     {fifo_rd_en_a, out_valid_a, out_data_a, out_last_a, busy_a});
        end
        checks++;
        if (pkt_count_a !== 16'd0) begin
            errors++;
            $display("FAIL rmid_pkt got %0d need 0", pkt_count_a);
        end
        // Both issued words are dropped by the reset.
        void'(exp_a.pop_front());
        void'(exp_a.pop_front());
        widx_a = 0;
        npkt_a = 0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        push_a(8'h53);
        push_a(8'h54);
        for (int i = 0; i < 50 && obs_a.size() < 4; i++) step();
        step();
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            n++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL rmid_extra got %h need none", o.d);
            end else begin
                e = exp_a.pop_front();
                el = (widx_a % 4 == 3);
                if (o.d !== e || o.l !== el) begin
                    errors++;
                    $display("FAIL rmid_word got %h/%b need %h/%b",
                             o.d, o.l, e, el);
                end
                widx_a++;
                if (el) npkt_a++;
            end
        end
        checks++;
        if (n != 4 || pkt_count_a !== 16'(npkt_a)) begin
            errors++;
            $display("FAIL rmid_count got %0d/%0d need 4/%0d",
                     n, pkt_count_a, npkt_a);
        end
    endtask

    task automatic test_pkt1();
        obs_t o;
        logic [7:0] e;
        int n;
        n = 0;
        for (int i = 1; i <= 3; i++) push_b(8'(8'h60 + i));
        for (int i = 0; i < 50 && obs_b.size() < 3; i++) step();
        step();
        while (obs_b.size() > 0) begin
            o = obs_b.pop_front();
            n++;
            checks++;
            e = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
            if (o.d !== e || o.l !== 1'b1) begin
                errors++;
                $display("FAIL pkt1_word got %h/%b need %h/1", o.d, o.l, e);
            end
        end
        checks++;
        if (n != 3 || pkt_count_b !== 16'd3) begin
            errors++;
            $display("FAIL pkt1_count got %0d/%0d need 3/3", n, pkt_count_b);
        end
        checks++;
        if (pop_err_b != 0) begin
            errors++;
            $display("FAIL pkt1_empty_read got %0d need 0", pop_err_b);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [7:0] e;
        logic el;
        int s0, v0;
        s0 = stab_err_a;
        v0 = over_err_a;
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) push_a(8'($urandom));
            step();
        end
        en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_a(8'($urandom));
        for (int i = 0; i < 200 && (busy_a || held_a != 0); i++) step();
        step();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL rnd_busy got %b need 0", busy_a);
        end
        while (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL rnd_extra got %h need none", o.d);
            end else begin
                e = exp_a.pop_front();
                el = (widx_a % 4 == 3);
                if (o.d !== e || o.l !== el) begin
                    errors++;
                    $display("FAIL rnd_word got %h/%b need %h/%b",
                             o.d, o.l, e, el);
                end
                widx_a++;
                if (el) npkt_a++;
            end
        end
        checks++;
        if (widx_a % 4 != 0) begin
            errors++;
            $display("FAIL rnd_partial got %0d need 0", widx_a % 4);
        end
        checks++;
        if (fq_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL rnd_left got %0d need %0d", fq_a.size(), exp_a.size());
        end
        checks++;
        if (pkt_count_a !== 16'(npkt_a)) begin
            errors++;
            $display("FAIL rnd_pkt got %0d need %0d", pkt_count_a, npkt_a);
        end
        checks++;
        if (stab_err_a != s0 || over_err_a != v0) begin
            errors++;
            $display("FAIL rnd_proto got %0d/%0d need %0d/%0d",
                     stab_err_a, over_err_a, s0, v0);
        end
        checks++;
        if (pop_err_a != 0 || rdemp_err_a != 0) begin
            errors++;
            $display("FAIL rnd_empty_read got %0d/%0d need 0/0",
                     pop_err_a, rdemp_err_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stop();
        test_empty_stall();
        test_reset_mid();
        test_pkt1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter WIDTH, default 8, data width; SHALL equal the width of the upstream sync_fifo data.
REQ-002 Parameter PKT_LEN, default 4, words per packet; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  run enable; high = stream words out of the FIFO.
REQ-006 fifo_empty  input  1  empty flag from sync_fifo.
REQ-007 fifo_rd_data  input  WIDTH  sync_fifo read data, valid the cycle after an accepted read.
REQ-008 fifo_rd_en  output  1  read strobe to sync_fifo.
REQ-009 out_valid  output  1  out_data/out_last valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  WIDTH  streamed word.
REQ-012 out_last  output  1  marks the final word of a packet.
REQ-013 pkt_count  output  16  completed packets since reset, wraps at 65535->0.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 Output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 FIFO read latency is 1: a read issued in cycle N returns data on fifo_rd_data in cycle N+1, and the block SHALL capture it in that cycle.
REQ-017 A 2-entry internal buffer SHALL hold captured words in order; out_data is always the oldest entry.
REQ-018 fifo_rd_en SHALL be asserted only when fifo_empty=0, the FSM permits issue, and (buffer occupancy + reads in flight) < 2 after counting the same-cycle output transfer.
REQ-019 With out_ready held at 1 and the FIFO non-empty, sustained throughput SHALL be 1 word per cycle.
REQ-020 FSM states: IDLE, RUN, STOP.
REQ-021 IDLE->RUN when en=1; RUN->STOP when en=0; STOP->RUN when en=1.
REQ-022 STOP->IDLE when iss_cnt=0, the buffer is empty, and no read is in flight.
REQ-023 IDLE issues no reads.
REQ-024 STOP issues reads only while iss_cnt!=0, so that only the current partial packet completes.
REQ-025 iss_cnt (0..PKT_LEN-1) SHALL increment on each issued read and wrap to 0 after PKT_LEN-1.
REQ-026 out_cnt SHALL track the same index on each output transfer; out_last=1 exactly when the head word has index PKT_LEN-1.
REQ-027 For PKT_LEN=1, every word SHALL have out_last=1.
REQ-028 pkt_count SHALL increment by 1 on each transfer with out_last=1.
REQ-029 fifo_empty=1 mid-packet SHALL stall issue without any state loss; the packet SHALL resume when data arrives, in RUN and in STOP alike.
REQ-030 Capture and output transfer in the same cycle SHALL leave occupancy unchanged and preserve word order.

Reset
REQ-031 Assertion of rst SHALL immediately set the following, independent of clk:
- state=IDLE
- fifo_rd_en=0, out_valid=0, out_data=0, out_last=0
- pkt_count=0, busy=0
- iss_cnt=0, out_cnt=0, buffer empty, in-flight flag cleared
REQ-032 Reset mid-packet SHALL discard buffered and in-flight words; the first post-reset word SHALL have index 0.
REQ-033 After rst deasserts, the first read SHALL issue no earlier than the first rising edge that sees en=1 and fifo_empty=0.

Verification
REQ-034 Scenario: PKT_LEN=4, FIFO preloaded with 8 words 0x01..0x08, en=1, out_ready=1 -> out_data 01..08 on consecutive cycles; out_last on 04 and 08; pkt_count=2.
REQ-035 Scenario: out_ready toggles 1,0,0,1,... while streaming -> no word lost or duplicated; data held stable during stalls; fifo_rd_en never asserted with 2 words buffered.
REQ-036 Scenario: en dropped after 2 words of a 4-word packet, FIFO holding 6 words -> exactly 2 more words read (03, 04); out_last on 04; then IDLE with busy=0; 2 words remain in the FIFO.
REQ-037 Scenario: FIFO empties after word 2 of a packet, refilled 5 cycles later -> packet resumes at index 2; out_last on the 4th word.
REQ-038 Scenario: rst pulsed with 1 word buffered and 1 read in flight -> all outputs 0 immediately; after release with en=1, the next out word has index 0 and pkt_count counts from 0.
REQ-039 Scenario: PKT_LEN=1, 3 words -> out_last=1 on all 3; pkt_count=3.
